// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding
// and the architectural constants used at reset.
package ifetch_unit_pkg;

    // Fetch sequencer states, in the order a normal fetch walks through them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } ifu_state_t;

    // addi x0, x0, 0 -- presented on instr before the first fetch completes.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // Boot address of the core.
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage : ifetch_unit_pkg

// File: rtl/ifetch_unit.sv
// Instruction fetch stage of the multicycle core. Owns the architectural PC,
// issues a single read per fetch on the instruction-memory port and presents
// the returned word to the control unit with a one-cycle ifu_finish pulse.
// Misaligned PCs are reported as a fault without touching the bus.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_valid,
    output logic              ifu_finish,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              ifu_fault,

    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,

    output logic              ireq_valid,
    output logic [ADDR_W-1:0] ireq_addr,
    input  logic              ireq_ready,
    input  logic              iresp_valid,
    input  logic [31:0]       iresp_data,
    input  logic              iresp_err
);

    ifu_state_t        state;
    ifu_state_t        state_next;
    logic [ADDR_W-1:0] pc;
    logic              pc_misaligned;
    logic              start_fetch;
    logic              start_fault;
    logic              resp_take;

    // Decode the events that move the FSM and load the output registers.
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign start_fetch   = (state == IDLE) && ifu_valid && !pc_misaligned;
    assign start_fault   = (state == IDLE) && ifu_valid &&  pc_misaligned;
    assign resp_take     = (state == WAIT) && iresp_valid;

    // State register; reset aborts any in-flight transaction back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: REQ waits for the handshake, WAIT for the response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_fault) begin
                    state_next = DONE;
                end else if (start_fetch) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ireq_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (iresp_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs: the request is held for all of REQ, finish only in DONE.
    always_comb begin
        ireq_valid = 1'b0;
        ifu_finish = 1'b0;
        case (state)
            REQ:     ireq_valid = 1'b1;
            DONE:    ifu_finish = 1'b1;
            default: begin
                ireq_valid = 1'b0;
                ifu_finish = 1'b0;
            end
        endcase
    end

    // Architectural PC, loaded by writeback in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (npc_valid) begin
            pc <= npc;
        end
    end

    // Request address is latched once per fetch so a PC update cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ireq_addr <= RESET_PC;
        end else if (start_fetch) begin
            ireq_addr <= pc;
        end
    end

    // Result registers change only when a fetch completes or faults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr     <= NOP_INSTR;
            instr_pc  <= RESET_PC;
            ifu_fault <= 1'b0;
        end else if (start_fault) begin
            instr_pc  <= pc;
            ifu_fault <= 1'b1;
        end else if (resp_take) begin
            instr     <= iresp_data;
            instr_pc  <= ireq_addr;
            ifu_fault <= iresp_err;
        end
    end

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. The bench plays the instruction memory
// with randomized stall/response timing and junk traffic, and predicts each
// fetch at transaction level: which address is requested, how many cycles
// until ifu_finish, and what instr/instr_pc/ifu_fault must show.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    localparam int          ADDR_W = 64;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ifu_valid = 1'b0;
    logic              ifu_finish;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              ifu_fault;
    logic              npc_valid = 1'b0;
    logic [ADDR_W-1:0] npc = '0;
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              ireq_ready = 1'b0;
    logic              iresp_valid = 1'b0;
    logic [31:0]       iresp_data = '0;
    logic              iresp_err = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level model of the architectural state visible to the consumer.
    logic [63:0] mdlPc;
    logic [31:0] mdlInstr;
    logic [63:0] mdlInstrPc;
    logic        mdlFault;

    ifetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu_valid   (ifu_valid),
        .ifu_finish  (ifu_finish),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .ifu_fault   (ifu_fault),
        .npc_valid   (npc_valid),
        .npc         (npc),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .ireq_ready  (ireq_ready),
        .iresp_valid (iresp_valid),
        .iresp_data  (iresp_data),
        .iresp_err   (iresp_err)
    );

    // 10 ns core clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks every output against its post-reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_finish"},    64'(ifu_finish), 64'd0);
        checkOutput({tag, "_instr"},     64'(instr),      64'(NOP_INSTR));
        checkOutput({tag, "_instr_pc"},  instr_pc,        RST_PC);
        checkOutput({tag, "_fault"},     64'(ifu_fault),  64'd0);
        checkOutput({tag, "_ireq_val"},  64'(ireq_valid), 64'd0);
        checkOutput({tag, "_ireq_addr"}, ireq_addr,       RST_PC);
    endtask

    task automatic modelReset();
        mdlPc      = RST_PC;
        mdlInstr   = NOP_INSTR;
        mdlInstrPc = RST_PC;
        mdlFault   = 1'b0;
    endtask

    // Writeback loads a new PC between fetches. Entered and left just after a negedge.
    task automatic loadPc(input logic [63:0] value);
        npc_valid = 1'b1;
        npc       = value;
        @(negedge clk);
        npc_valid = 1'b0;
        mdlPc     = value;
    endtask

    // One complete fetch. stalls = REQ cycles with ready low, waits = WAIT cycles
    // before the response, dropValid releases ifu_valid mid-fetch, npcAt (>0)
    // pulses a PC update on that cycle of the fetch. Entered/left after a negedge.
    task automatic applyStimulus(input int stalls, input int waits,
                                 input logic [31:0] data, input logic err,
                                 input bit dropValid, input int npcAt,
                                 input logic [63:0] npcVal);
        logic [63:0] expAddr;
        logic [31:0] expInstr;
        logic        expFault;
        bit          misaligned;
        int          expLat;
        int          cycles;
        int          stallCnt;
        int          waitCnt;
        int          accepts;
        bit          done;
        bit          prevValid;
        bit          prevReady;

        expAddr    = mdlPc;
        misaligned = (mdlPc[1:0] != 2'b00);
        expLat     = misaligned ? 1 : 3 + stalls + waits;
        expInstr   = misaligned ? mdlInstr : data;
        expFault   = misaligned ? 1'b1 : err;

        ifu_valid   = 1'b1;
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
        cycles      = 0;
        stallCnt    = 0;
        waitCnt     = 0;
        accepts     = 0;
        done        = 1'b0;
        prevValid   = 1'b0;
        prevReady   = 1'b0;

        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (prevValid && prevReady) accepts++;
            npc_valid = 1'b0;
            if (ifu_finish) begin
                done = 1'b1;
                checkOutput("latency",    64'(cycles),     64'(expLat));
                checkOutput("instr",      64'(instr),      64'(expInstr));
                checkOutput("instr_pc",   instr_pc,        expAddr);
                checkOutput("fault",      64'(ifu_fault),  64'(expFault));
                checkOutput("accepts",    64'(accepts),    misaligned ? 64'd0 : 64'd1);
                checkOutput("done_noreq", 64'(ireq_valid), 64'd0);
                iresp_valid = 1'b0;
            end else begin
                if (ireq_valid) begin
                    checkOutput("ireq_addr", ireq_addr, expAddr);
                    if (misaligned) checkOutput("misaligned_req", 64'd1, 64'd0);
                    if (stallCnt < stalls) begin
                        ireq_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        ireq_ready = 1'b1;
                    end
                    // Stray response traffic during REQ must be ignored.
                    iresp_valid = 1'($urandom_range(0, 1));
                    iresp_data  = $urandom;
                    iresp_err   = 1'($urandom_range(0, 1));
                end else if (accepts == 1) begin
                    ireq_ready = 1'($urandom_range(0, 1));
                    if (waitCnt < waits) begin
                        iresp_valid = 1'b0;
                        iresp_data  = $urandom;
                        waitCnt++;
                    end else begin
                        iresp_valid = 1'b1;
                        iresp_data  = data;
                        iresp_err   = err;
                    end
                end else begin
                    ireq_ready  = 1'b0;
                    iresp_valid = 1'b0;
                end
                if (dropValid) ifu_valid = 1'b0;
                if (npcAt > 0 && cycles == npcAt) begin
                    npc_valid = 1'b1;
                    npc       = npcVal;
                    mdlPc     = npcVal;
                end
            end
            prevValid = ireq_valid;
            prevReady = ireq_ready;
        end
        if (!done) checkOutput("timeout", 64'd0, 64'd1);

        mdlInstr   = expInstr;
        mdlInstrPc = expAddr;
        mdlFault   = expFault;

        ifu_valid   = 1'b0;
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
        npc_valid   = 1'b0;
        @(negedge clk);
        checkOutput("finish_pulse", 64'(ifu_finish), 64'd0);
        checkOutput("instr_hold",   64'(instr),      64'(mdlInstr));
        checkOutput("fault_hold",   64'(ifu_fault),  64'(mdlFault));
    endtask

    // Reset pulled during WAIT, then a late response right after release.
    task automatic resetMidWait();
        ifu_valid  = 1'b1;
        ireq_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_seen", 64'(ireq_valid), 64'd1);
        ireq_ready = 1'b1;
        @(negedge clk);
        ireq_ready = 1'b0;
        ifu_valid  = 1'b0;
        #1 rst_n = 1'b0;
        #1 checkResetValues("midrst");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        iresp_valid = 1'b1;
        iresp_data  = 32'hBAD0_0BAD;
        iresp_err   = 1'b1;
        @(negedge clk);
        iresp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("late_resp_finish", 64'(ifu_finish), 64'd0);
            checkOutput("late_resp_instr",  64'(instr),      64'(NOP_INSTR));
            checkOutput("late_resp_fault",  64'(ifu_fault),  64'd0);
            @(negedge clk);
        end
    endtask

    // Random PC: mostly aligned, occasionally misaligned.
    function automatic logic [63:0] randomPc();
        logic [63:0] v;
        v = {32'h0000_0000, 2'b10, 30'($urandom)};
        if ($urandom_range(0, 5) == 0) begin
            v[1:0] = 2'($urandom_range(1, 3));
        end else begin
            v[1:0] = 2'b00;
        end
        return v;
    endfunction

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] first fetch after reset");
        applyStimulus(0, 0, 32'h0010_0093, 1'b0, 1'b0, 0, '0);

        $display("[TB] ready stall and response wait");
        applyStimulus(3, 2, 32'h0020_8113, 1'b0, 1'b0, 0, '0);

        $display("[TB] misaligned PC fault");
        loadPc(64'h0000_0000_8000_0102);
        applyStimulus(0, 0, 32'h1234_5678, 1'b0, 1'b0, 0, '0);

        $display("[TB] bus error response");
        loadPc(64'h0000_0000_8000_0100);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, '0);

        $display("[TB] PC update during WAIT");
        loadPc(64'h0000_0000_8000_0200);
        applyStimulus(1, 2, 32'h0000_0517, 1'b0, 1'b1, 3, 64'h0000_0000_8000_0010);
        applyStimulus(0, 0, 32'h0000_0297, 1'b0, 1'b0, 0, '0);

        $display("[TB] reset during WAIT");
        resetMidWait();
        applyStimulus(0, 0, 32'h0040_0193, 1'b0, 1'b0, 0, '0);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 40; n++) begin
            int          st;
            int          wt;
            int          lat;
            int          at;
            logic [63:0] midPc;
            if ($urandom_range(0, 2) == 0) loadPc(randomPc());
            st    = $urandom_range(0, 3);
            wt    = $urandom_range(0, 3);
            lat   = (mdlPc[1:0] != 2'b00) ? 1 : 3 + st + wt;
            at    = 0;
            midPc = randomPc();
            if (lat > 1 && $urandom_range(0, 2) == 0) at = $urandom_range(1, lat - 1);
            applyStimulus(st, wt, $urandom, 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), at, midPc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_ifetch_unit
